// File: rtl/id_ex_alu_decode.sv
// rtl/id_ex_alu_decode.sv - ID-stage ALU decode feeding the ID/EX pipeline register
module id_ex_alu_decode #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             Instr_D,
    input  logic                    Valid_D,
    input  logic [31:0]             RD1_D,
    input  logic [31:0]             RD2_D,
    input  logic [31:0]             PCPlus8_D,
    input  logic                    Stall_E,
    input  logic                    Flush_E,
    output logic [4:0]              ALUControl_E,
    output logic [31:0]             SrcA_E,
    output logic [31:0]             SrcB_E,
    output logic                    RegWrite_E,
    output logic [4:0]              WriteReg_E,
    output logic                    MemWrite_E,
    output logic                    MemtoReg_E,
    output logic                    Branch_E,
    output logic                    Jump_E,
    output logic [31:0]             StoreData_E,
    output logic                    Valid_E,
    output logic                    IllegalInstr_E,
    output logic [BUBBLE_CNT_W-1:0] BubbleCount
);

    localparam logic [4:0] ALUctr_ADD   = 5'd0;
    localparam logic [4:0] ALUctr_ADDU  = 5'd1;
    localparam logic [4:0] ALUctr_SUB   = 5'd2;
    localparam logic [4:0] ALUctr_SUBU  = 5'd3;
    localparam logic [4:0] ALUctr_AND   = 5'd4;
    localparam logic [4:0] ALUctr_OR    = 5'd5;
    localparam logic [4:0] ALUctr_XOR   = 5'd6;
    localparam logic [4:0] ALUctr_NOR   = 5'd7;
    localparam logic [4:0] ALUctr_SLT   = 5'd8;
    localparam logic [4:0] ALUctr_SLL   = 5'd9;
    localparam logic [4:0] ALUctr_SRL   = 5'd10;
    localparam logic [4:0] ALUctr_SRA   = 5'd11;
    localparam logic [4:0] ALUctr_SLLV  = 5'd12;
    localparam logic [4:0] ALUctr_SRLV  = 5'd13;
    localparam logic [4:0] ALUctr_SRAV  = 5'd14;
    localparam logic [4:0] ALUctr_JR    = 5'd15;
    localparam logic [4:0] ALUctr_ADDI  = 5'd16;
    localparam logic [4:0] ALUctr_ADDIU = 5'd17;
    localparam logic [4:0] ALUctr_ANDI  = 5'd18;
    localparam logic [4:0] ALUctr_ORI   = 5'd19;
    localparam logic [4:0] ALUctr_XORI  = 5'd20;
    localparam logic [4:0] ALUctr_LW    = 5'd21;
    localparam logic [4:0] ALUctr_SW    = 5'd22;
    localparam logic [4:0] ALUctr_BEQ   = 5'd23;
    localparam logic [4:0] ALUctr_BNE   = 5'd24;
    localparam logic [4:0] ALUctr_J     = 5'd25;
    localparam logic [4:0] ALUctr_JAL   = 5'd26;

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sx, imm_zx;

    assign op     = Instr_D[31:26];
    assign rt     = Instr_D[20:16];
    assign rd     = Instr_D[15:11];
    assign shamt  = Instr_D[10:6];
    assign funct  = Instr_D[5:0];
    assign imm    = Instr_D[15:0];
    assign imm_sx = {{16{imm[15]}}, imm};
    assign imm_zx = {16'b0, imm};

    // rs selects the register file read; its value arrives already forwarded on RD1_D
    logic unused_rs;
    assign unused_rs = ^Instr_D[25:21];

    logic [4:0]  dec_ctrl, dec_wreg;
    logic [31:0] dec_srca, dec_srcb, dec_store;
    logic        dec_rw, dec_mw, dec_m2r, dec_br, dec_jmp, dec_legal;

    always_comb begin
        dec_ctrl  = ALUctr_J;
        dec_srca  = RD1_D;
        dec_srcb  = RD2_D;
        dec_wreg  = 5'd0;
        dec_rw    = 1'b0;
        dec_mw    = 1'b0;
        dec_m2r   = 1'b0;
        dec_br    = 1'b0;
        dec_jmp   = 1'b0;
        dec_store = 32'd0;
        dec_legal = 1'b1;
        case (op)
            6'h00: begin
                dec_wreg = rd;
                dec_rw   = 1'b1;
                case (funct)
                    6'h20: dec_ctrl = ALUctr_ADD;
                    6'h21: dec_ctrl = ALUctr_ADDU;
                    6'h22: dec_ctrl = ALUctr_SUB;
                    6'h23: dec_ctrl = ALUctr_SUBU;
                    6'h24: dec_ctrl = ALUctr_AND;
                    6'h25: dec_ctrl = ALUctr_OR;
                    6'h26: dec_ctrl = ALUctr_XOR;
                    6'h27: dec_ctrl = ALUctr_NOR;
                    6'h2A: dec_ctrl = ALUctr_SLT;
                    6'h00: begin dec_ctrl = ALUctr_SLL;  dec_srca = {27'b0, shamt}; end
                    6'h02: begin dec_ctrl = ALUctr_SRL;  dec_srca = {27'b0, shamt}; end
                    6'h03: begin dec_ctrl = ALUctr_SRA;  dec_srca = {27'b0, shamt}; end
                    6'h04: begin dec_ctrl = ALUctr_SLLV; dec_srca = {27'b0, RD1_D[4:0]}; end
                    6'h06: begin dec_ctrl = ALUctr_SRLV; dec_srca = {27'b0, RD1_D[4:0]}; end
                    6'h07: begin dec_ctrl = ALUctr_SRAV; dec_srca = {27'b0, RD1_D[4:0]}; end
                    6'h08: begin
                        dec_ctrl = ALUctr_JR;
                        dec_srcb = 32'd0;
                        dec_wreg = 5'd0;
                        dec_rw   = 1'b0;
                        dec_jmp  = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_ctrl = ALUctr_ADDI;  dec_srcb = imm_sx; dec_wreg = rt; dec_rw = 1'b1; end
            6'h09: begin dec_ctrl = ALUctr_ADDIU; dec_srcb = imm_sx; dec_wreg = rt; dec_rw = 1'b1; end
            6'h0C: begin dec_ctrl = ALUctr_ANDI;  dec_srcb = imm_zx; dec_wreg = rt; dec_rw = 1'b1; end
            6'h0D: begin dec_ctrl = ALUctr_ORI;   dec_srcb = imm_zx; dec_wreg = rt; dec_rw = 1'b1; end
            6'h0E: begin dec_ctrl = ALUctr_XORI;  dec_srcb = imm_zx; dec_wreg = rt; dec_rw = 1'b1; end
            6'h23: begin
                dec_ctrl = ALUctr_LW;
                dec_srcb = imm_sx;
                dec_wreg = rt;
                dec_rw   = 1'b1;
                dec_m2r  = 1'b1;
            end
            6'h2B: begin
                dec_ctrl  = ALUctr_SW;
                dec_srcb  = imm_sx;
                dec_mw    = 1'b1;
                dec_store = RD2_D;
            end
            6'h04: begin dec_ctrl = ALUctr_BEQ; dec_br = 1'b1; end
            6'h05: begin dec_ctrl = ALUctr_BNE; dec_br = 1'b1; end
            6'h02: begin
                dec_ctrl = ALUctr_J;
                dec_srca = 32'd0;
                dec_srcb = 32'd0;
                dec_jmp  = 1'b1;
            end
            6'h03: begin
                dec_ctrl = ALUctr_JAL;
                dec_srca = 32'd0;
                dec_srcb = PCPlus8_D;
                dec_wreg = 5'd31;
                dec_rw   = 1'b1;
                dec_jmp  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic [4:0]              n_ctrl, n_wreg;
    logic [31:0]             n_srca, n_srcb, n_store;
    logic                    n_rw, n_mw, n_m2r, n_br, n_jmp, n_valid, n_illegal;
    logic [BUBBLE_CNT_W-1:0] n_bc, bc_inc;

    assign bc_inc = (&BubbleCount) ? BubbleCount
                                   : BubbleCount + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

    // Start from "hold"; a flush or an unstalled cycle overwrites with a bubble first
    always_comb begin
        n_ctrl    = ALUControl_E;
        n_srca    = SrcA_E;
        n_srcb    = SrcB_E;
        n_rw      = RegWrite_E;
        n_wreg    = WriteReg_E;
        n_mw      = MemWrite_E;
        n_m2r     = MemtoReg_E;
        n_br      = Branch_E;
        n_jmp     = Jump_E;
        n_store   = StoreData_E;
        n_valid   = Valid_E;
        n_illegal = IllegalInstr_E;
        n_bc      = BubbleCount;
        if (Flush_E || !Stall_E) begin
            n_ctrl    = ALUctr_J;
            n_srca    = 32'd0;
            n_srcb    = 32'd0;
            n_rw      = 1'b0;
            n_wreg    = 5'd0;
            n_mw      = 1'b0;
            n_m2r     = 1'b0;
            n_br      = 1'b0;
            n_jmp     = 1'b0;
            n_store   = 32'd0;
            n_valid   = 1'b0;
            n_illegal = 1'b0;
            if (Flush_E || !Valid_D) begin
                n_bc = bc_inc;
            end else if (!dec_legal) begin
                n_valid   = 1'b1;
                n_illegal = 1'b1;
            end else begin
                n_ctrl  = dec_ctrl;
                n_srca  = dec_srca;
                n_srcb  = dec_srcb;
                n_rw    = dec_rw && (dec_wreg != 5'd0);
                n_wreg  = dec_wreg;
                n_mw    = dec_mw;
                n_m2r   = dec_m2r;
                n_br    = dec_br;
                n_jmp   = dec_jmp;
                n_store = dec_store;
                n_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUControl_E   <= ALUctr_J;
            SrcA_E         <= 32'd0;
            SrcB_E         <= 32'd0;
            RegWrite_E     <= 1'b0;
            WriteReg_E     <= 5'd0;
            MemWrite_E     <= 1'b0;
            MemtoReg_E     <= 1'b0;
            Branch_E       <= 1'b0;
            Jump_E         <= 1'b0;
            StoreData_E    <= 32'd0;
            Valid_E        <= 1'b0;
            IllegalInstr_E <= 1'b0;
            BubbleCount    <= '0;
        end else begin
            ALUControl_E   <= n_ctrl;
            SrcA_E         <= n_srca;
            SrcB_E         <= n_srcb;
            RegWrite_E     <= n_rw;
            WriteReg_E     <= n_wreg;
            MemWrite_E     <= n_mw;
            MemtoReg_E     <= n_m2r;
            Branch_E       <= n_br;
            Jump_E         <= n_jmp;
            StoreData_E    <= n_store;
            Valid_E        <= n_valid;
            IllegalInstr_E <= n_illegal;
            BubbleCount    <= n_bc;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// tb/tb_id_ex_alu_decode.sv - scoreboard bench for id_ex_alu_decode
module tb_id_ex_alu_decode;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic        rw;
        logic [4:0]  wreg;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        jmp;
        logic [31:0] store;
        logic        valid;
        logic        illegal;
        logic [15:0] bc;
    } out_t;

    localparam logic [4:0] C_ADD = 5'd0,  C_SLT = 5'd8,  C_SLL = 5'd9,  C_SRAV = 5'd14;
    localparam logic [4:0] C_JR  = 5'd15, C_ADDI = 5'd16, C_ANDI = 5'd18, C_ORI = 5'd19;
    localparam logic [4:0] C_LW  = 5'd21, C_SW = 5'd22,  C_BEQ = 5'd23, C_J = 5'd25, C_JAL = 5'd26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr_D, RD1_D, RD2_D, PCPlus8_D;
    logic        Valid_D, Stall_E, Flush_E;

    logic [4:0]  ALUControl_E, WriteReg_E;
    logic [31:0] SrcA_E, SrcB_E, StoreData_E;
    logic        RegWrite_E, MemWrite_E, MemtoReg_E, Branch_E, Jump_E, Valid_E, IllegalInstr_E;
    logic [15:0] BubbleCount;

    logic [4:0]  s_ctrl, s_wreg;
    logic [31:0] s_srca, s_srcb, s_store;
    logic        s_rw, s_mw, s_m2r, s_br, s_jmp, s_valid, s_illegal;
    logic [1:0]  s_bc;

    always #5 clk = ~clk;

    id_ex_alu_decode dut (
        .clk(clk), .rst_n(rst_n), .Instr_D(Instr_D), .Valid_D(Valid_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .PCPlus8_D(PCPlus8_D),
        .Stall_E(Stall_E), .Flush_E(Flush_E),
        .ALUControl_E(ALUControl_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
        .RegWrite_E(RegWrite_E), .WriteReg_E(WriteReg_E), .MemWrite_E(MemWrite_E),
        .MemtoReg_E(MemtoReg_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
        .StoreData_E(StoreData_E), .Valid_E(Valid_E), .IllegalInstr_E(IllegalInstr_E),
        .BubbleCount(BubbleCount)
    );

    id_ex_alu_decode #(.BUBBLE_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .Instr_D(Instr_D), .Valid_D(Valid_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .PCPlus8_D(PCPlus8_D),
        .Stall_E(Stall_E), .Flush_E(Flush_E),
        .ALUControl_E(s_ctrl), .SrcA_E(s_srca), .SrcB_E(s_srcb),
        .RegWrite_E(s_rw), .WriteReg_E(s_wreg), .MemWrite_E(s_mw),
        .MemtoReg_E(s_m2r), .Branch_E(s_br), .Jump_E(s_jmp),
        .StoreData_E(s_store), .Valid_E(s_valid), .IllegalInstr_E(s_illegal),
        .BubbleCount(s_bc)
    );

    out_t act;
    assign act = {ALUControl_E, SrcA_E, SrcB_E, RegWrite_E, WriteReg_E, MemWrite_E,
                  MemtoReg_E, Branch_E, Jump_E, StoreData_E, Valid_E, IllegalInstr_E,
                  BubbleCount};

    out_t        sb[$];
    logic [1:0]  sb_sat[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_bc = 16'd0;

    function automatic out_t mk(input logic [4:0] ctrl, input logic [31:0] srca, srcb,
                                input logic rw, input logic [4:0] wreg,
                                input logic mw, m2r, br, jmp, input logic [31:0] store,
                                input logic valid, illegal);
        out_t e;
        e = {ctrl, srca, srcb, rw, wreg, mw, m2r, br, jmp, store, valid, illegal, exp_bc};
        return e;
    endfunction

    function automatic out_t bubble();
        return mk(C_J, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic [31:0] r1, r2, pc8,
                         input logic st, fl, rn, input out_t e);
        Instr_D   = ins;
        Valid_D   = v;
        RD1_D     = r1;
        RD2_D     = r2;
        PCPlus8_D = pc8;
        Stall_E   = st;
        Flush_E   = fl;
        rst_n     = rn;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        out_t e;
        exp_bc = 16'd0;
        for (int i = 0; i < 2; i++) begin
            drive(32'h02328020, 1'b1, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, bubble());
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want %h", i, act, e);
            end
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins, r1, r2, pc8;
        out_t e;
        for (int i = 0; i < 13; i++) begin
            pc8 = 32'd0;
            r1  = 32'h0000_000A;
            r2  = 32'h0000_0014;
            case (i)
                0: begin ins = 32'h02328020; e = mk(C_ADD, r1, r2, 1, 16, 0, 0, 0, 0, 0, 1, 0); end
                1: begin ins = 32'h2228FFFF; r1 = 5; r2 = 32'h77;
                         e = mk(C_ADDI, 5, 32'hFFFF_FFFF, 1, 8, 0, 0, 0, 0, 0, 1, 0); end
                2: begin ins = 32'h3628FFFF; r1 = 5;
                         e = mk(C_ORI, 5, 32'h0000_FFFF, 1, 8, 0, 0, 0, 0, 0, 1, 0); end
                3: begin ins = 32'h00114100; r1 = 32'h99; r2 = 3;
                         e = mk(C_SLL, 4, 3, 1, 8, 0, 0, 0, 0, 0, 1, 0); end
                4: begin ins = 32'h02328007; r1 = 32'h25; r2 = 32'h8000_0000;
                         e = mk(C_SRAV, 5, 32'h8000_0000, 1, 16, 0, 0, 0, 0, 0, 1, 0); end
                5: begin ins = 32'h02320020; e = mk(C_ADD, r1, r2, 0, 0, 0, 0, 0, 0, 0, 1, 0); end
                6: begin ins = 32'h0C000010; pc8 = 32'h0040_0008; r1 = 1; r2 = 2;
                         e = mk(C_JAL, 0, 32'h0040_0008, 1, 31, 0, 0, 0, 1, 0, 1, 0); end
                7: begin ins = 32'h02200008; r1 = 32'h1234;
                         e = mk(C_JR, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); end
                8: begin ins = 32'h12320003; r1 = 7; r2 = 7;
                         e = mk(C_BEQ, 7, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0); end
                9: begin ins = 32'h8E28FFFC; r1 = 32'h1000;
                         e = mk(C_LW, 32'h1000, 32'hFFFF_FFFC, 1, 8, 0, 1, 0, 0, 0, 1, 0); end
                10: begin ins = 32'h0232802A; e = mk(C_SLT, r1, r2, 1, 16, 0, 0, 0, 0, 0, 1, 0); end
                11: begin ins = 32'h08000020; e = mk(C_J, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); end
                default: begin ins = 32'h32288001;
                         e = mk(C_ANDI, r1, 32'h0000_8001, 1, 8, 0, 0, 0, 0, 0, 1, 0); end
            endcase
            drive(ins, 1'b1, r1, r2, pc8, 1'b0, 1'b0, 1'b1, e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL decode[%0d] instr=%h: got %h want %h", i, ins, act, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        out_t e_sw, e_add, e;
        e_sw  = mk(C_SW, 32'h100, 32'd4, 0, 0, 1, 0, 0, 0, 32'hDEAD, 1, 0);
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: drive(32'hAE320004, 1'b1, 32'h100, 32'hDEAD, 0, 1'b0, 1'b0, 1'b1, e_sw);
                1: drive(32'h02328020, 1'b1, 32'h1, 32'h2, 0, 1'b1, 1'b0, 1'b1, e_sw);
                2: drive(32'h02328020, 1'b0, 32'h3, 32'h4, 0, 1'b1, 1'b0, 1'b1, e_sw);
                3: drive(32'hFC000000, 1'b1, 32'h5, 32'h6, 0, 1'b1, 1'b0, 1'b1, e_sw);
                4: begin exp_bc++; drive(32'h02328020, 1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b1, bubble()); end
                5: begin exp_bc++; drive(32'h02328020, 1'b0, 1, 2, 0, 1'b0, 1'b0, 1'b1, bubble()); end
                6: drive(32'h02328020, 1'b0, 1, 2, 0, 1'b1, 1'b0, 1'b1, bubble());
                7: begin
                    e_add = mk(C_ADD, 32'd9, 32'd11, 1, 16, 0, 0, 0, 0, 0, 1, 0);
                    drive(32'h02328020, 1'b1, 32'd9, 32'd11, 0, 1'b0, 1'b0, 1'b1, e_add);
                end
                default: begin exp_bc = 16'd0; drive(32'h02328020, 1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0, bubble()); end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL stall_flush[%0d]: got %h want %h", i, act, e);
            end
        end
    endtask

    task automatic test_illegal();
        out_t e_ill, e;
        e_ill = mk(C_J, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(32'hFC000000, 1'b1, 32'h55, 32'h66, 0, 1'b0, 1'b0, 1'b1, e_ill);
                1: drive(32'h02328020, 1'b1, 32'h1, 32'h2, 0, 1'b1, 1'b0, 1'b1, e_ill);
                2: drive(32'h02328020, 1'b0, 32'h1, 32'h2, 0, 1'b1, 1'b0, 1'b1, e_ill);
                3: drive(32'h00000001, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, 1'b1, e_ill);
                default: drive(32'h2228FFFF, 1'b1, 32'd5, 32'd0, 0, 1'b0, 1'b0, 1'b1,
                               mk(C_ADDI, 5, 32'hFFFF_FFFF, 1, 8, 0, 0, 0, 0, 0, 1, 0));
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %h want %h", i, act, e);
            end
        end
    endtask

    task automatic test_saturation();
        out_t       e;
        logic [1:0] es;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                exp_bc = 16'd0;
                sb_sat.push_back(2'd0);
                drive(32'd0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, bubble());
            end else begin
                exp_bc++;
                sb_sat.push_back((i > 3) ? 2'd3 : 2'(i));
                drive(32'd0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, bubble());
            end
            @(posedge clk); #1;
            e  = sb.pop_front();
            es = sb_sat.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL bubble_count[%0d]: got %h want %h", i, act, e);
            end
            n_cmp++;
            if (s_bc !== es) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %0d want %0d", i, s_bc, es);
            end
        end
    endtask

    initial begin
        Instr_D = 32'd0; Valid_D = 1'b0; RD1_D = 32'd0; RD2_D = 32'd0; PCPlus8_D = 32'd0;
        Stall_E = 1'b0; Flush_E = 1'b0; rst_n = 1'b0;
        test_reset();
        test_decode();
        test_stall_flush();
        test_illegal();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_decode.md
# id_ex_alu_decode

Decode-to-execute issue stage for the 5-stage MIPS pipeline. It decodes the ID-stage instruction into the 5-bit `ALUctr_*` code, builds the ALU operands `SrcA`/`SrcB` (shift amounts, extended immediates, link address) and the EX-stage write and memory controls. It holds everything in the ID/EX pipeline register, with stall, flush and bubble handling. Its outputs drive the ALU's `SrcA`, `SrcB` and `ALUControl` inputs directly; it is the producing end of that interface.

## Interface
- `BUBBLE_CNT_W`, default 16: width of the saturating bubble counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `Instr_D` in 32: instruction in ID.
- `Valid_D` in 1: `Instr_D` is a real instruction.
- `RD1_D`, `RD2_D` in 32 each: forwarded rs and rt register values.
- `PCPlus8_D` in 32: link address for jal.
- `Stall_E` in 1: hold the ID/EX register.
- `Flush_E` in 1: replace the ID/EX contents with a bubble.
- `ALUControl_E` out 5: `ALUctr_*` code (encodings from config.v).
- `SrcA_E`, `SrcB_E` out 32 each: ALU operands.
- `RegWrite_E` out 1; `WriteReg_E` out 5; `MemWrite_E` out 1; `MemtoReg_E` out 1; `Branch_E` out 1; `Jump_E` out 1.
- `StoreData_E` out 32: rt value for sw.
- `Valid_E` out 1: register holds a real instruction.
- `IllegalInstr_E` out 1: the held instruction did not decode.
- `BubbleCount` out `BUBBLE_CNT_W`: count of bubbles inserted.

## Operation
- Fields: `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `shamt=[10:6]`, `funct=[5:0]`, `imm=[15:0]`.
- R-type (`op=0`), decoded by `funct`:
  - Arithmetic/logic: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT. `SrcA=RD1`, `SrcB=RD2`, `WriteReg=rd`.
  - Fixed shifts: 0x00 SLL, 0x02 SRL, 0x03 SRA. `SrcA={27'b0,shamt}`, `SrcB=RD2`, `WriteReg=rd`.
  - Variable shifts: 0x04 SLLV, 0x06 SRLV, 0x07 SRAV. `SrcA={27'b0,RD1[4:0]}`, `SrcB=RD2`, `WriteReg=rd`.
  - 0x08 JR: code `ALUctr_JR`, `Jump=1`, no register write.
- I-type, decoded by `op`:
  - ADDI 0x08, ADDIU 0x09: `SrcB=sign-ext(imm)`, `WriteReg=rt`.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: `SrcB=zero-ext(imm)`, `WriteReg=rt`.
  - LW 0x23: `SrcB=sign-ext(imm)`, `MemtoReg=1`, `WriteReg=rt`.
  - SW 0x2B: `SrcB=sign-ext(imm)`, `MemWrite=1`, `StoreData=RD2`, no register write.
  - BEQ 0x04, BNE 0x05: `SrcA=RD1`, `SrcB=RD2`, `Branch=1`, no register write.
  - J 0x02: code `ALUctr_J`, `Jump=1`.
  - JAL 0x03: code `ALUctr_JAL`, `SrcB=PCPlus8_D`, `WriteReg=31`, `RegWrite=1`, `Jump=1`.
- `RegWrite` is forced to 0 whenever `WriteReg==0`.
- Illegal instruction (any other op/funct with `Valid_D=1`): load a bubble, but with `Valid_E=1` and `IllegalInstr_E=1`.
- Bubble contents: `ALUControl_E=ALUctr_J`; `SrcA`, `SrcB`, `StoreData` and `WriteReg` all 0; all enables 0; `Valid_E=0`; `IllegalInstr_E=0`.
- Register update priority, highest first:
  1. `!rst_n`: bubble, `BubbleCount=0`.
  2. `Flush_E`: bubble, `BubbleCount+1`.
  3. `Stall_E`: hold all outputs.
  4. `!Valid_D`: bubble, `BubbleCount+1`.
  5. Otherwise: load the decoded values.
- `BubbleCount` saturates at all-ones; it never wraps.

## Timing
- Latency is 1 cycle: values present at edge N appear on the outputs after edge N.
- Decode is purely combinational ahead of the register. The decode-to-ALU path has no extra register.
- Reset values: every output equals bubble contents; `BubbleCount=0`.
- Reset is synchronous. If `rst_n` is low mid-stall, the next edge clears the register regardless of `Stall_E`.
- `Flush_E` and `Stall_E` both high: flush wins and one bubble is counted.
- A stall that lasts any number of cycles leaves all outputs bit-identical, including `IllegalInstr_E`. `BubbleCount` does not change during a stall.
- `Stall_E` with `Valid_D=0`: hold; no bubble is counted.

## Test plan
- Reset: hold `rst_n=0` for 2 edges with `Instr_D=0x02328020` (add) present -> `ALUControl_E=ALUctr_J`, all enables 0, `Valid_E=0`, `BubbleCount=0`.
- Decode ADDI: `Instr_D=0x2228FFFF` (addi $8,$17,-1), `RD1=5` -> `ALUctr_ADDI`, `SrcA=5`, `SrcB=0xFFFFFFFF`, `WriteReg=8`, `RegWrite=1`.
- Decode ORI and SLL:
  - `Instr_D=0x3628FFFF` (ori) -> `SrcB=0x0000FFFF`.
  - `Instr_D=0x00114100` (sll $8,$17,4), `RD2=3` -> `SrcA=4`, `SrcB=3`, `WriteReg=8`.
- Decode JAL: `Instr_D=0x0C000010`, `PCPlus8_D=0x00400008` -> `ALUctr_JAL`, `SrcB=0x00400008`, `WriteReg=31`, `RegWrite=1`, `Jump=1`.
- Stall/flush: load sw, assert `Stall_E` for 3 cycles -> outputs held, `MemWrite_E=1`. Then assert `Stall_E` and `Flush_E` together -> bubble, `BubbleCount` increments by exactly 1.
- Illegal and saturation:
  - `Instr_D=0xFC000000` -> `IllegalInstr_E=1`, `Valid_E=1`, `RegWrite_E=0`.
  - With `BUBBLE_CNT_W=2`, insert 5 bubbles -> `BubbleCount=3`.
